// File: rtl/hyperbus_mem_responder_if.sv
// HyperBus pin bundle between a bus controller and the memory responder.
// The controller drives CS#/CK/DQ/RWDS; the responder returns read data.
interface hyperbus_mem_responder_if;
  logic       hyper_reset_ni;
  logic       hyper_cs_ni;
  logic       hyper_ck_i;
  logic [7:0] hyper_dq_i;
  logic       hyper_rwds_i;
  logic [7:0] hyper_dq_o;
  logic       hyper_dq_oe_o;
  logic       hyper_rwds_o;
  logic       hyper_rwds_oe_o;

  modport master (
    output hyper_reset_ni,
    output hyper_cs_ni,
    output hyper_ck_i,
    output hyper_dq_i,
    output hyper_rwds_i,
    input  hyper_dq_o,
    input  hyper_dq_oe_o,
    input  hyper_rwds_o,
    input  hyper_rwds_oe_o
  );

  modport slave (
    input  hyper_reset_ni,
    input  hyper_cs_ni,
    input  hyper_ck_i,
    input  hyper_dq_i,
    input  hyper_rwds_i,
    output hyper_dq_o,
    output hyper_dq_oe_o,
    output hyper_rwds_o,
    output hyper_rwds_oe_o
  );
endinterface

// File: rtl/hyperbus_mem_responder.sv
// Oversampled HyperRAM-style responder: CK/CS# are sampled as data by clk_i,
// 16-bit word array plus ID0/CR0 register space.
module hyperbus_mem_responder #(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 6,
  parameter logic [15:0] ID0_VALUE = 16'h0C81,
  parameter logic [15:0] CR0_RESET = 16'h8F1F
) (
  input logic                   clk_i,
  input logic                   rst_i,
  hyperbus_mem_responder_if.slave bus
);

  localparam int LAT_EDGES = 4 * LATENCY;
  localparam int LAT_W     = $clog2(LAT_EDGES);

  typedef enum logic [2:0] {
    IDLE, CA, LAT, WDATA, RDATA, REGWR, DONE
  } state_t;

  logic       cs_s1, cs_s2;
  logic       ck_s1, ck_s2, ck_s3;
  logic       rn_s1, rn_s2;
  logic [7:0] dq_d1, dq_d2;
  logic       rw_d1, rw_d2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_s1 <= 1'b1;
      cs_s2 <= 1'b1;
      ck_s1 <= 1'b0;
      ck_s2 <= 1'b0;
      ck_s3 <= 1'b0;
      rn_s1 <= 1'b1;
      rn_s2 <= 1'b1;
      dq_d1 <= '0;
      dq_d2 <= '0;
      rw_d1 <= 1'b0;
      rw_d2 <= 1'b0;
    end else begin
      cs_s1 <= bus.hyper_cs_ni;
      cs_s2 <= cs_s1;
      ck_s1 <= bus.hyper_ck_i;
      ck_s2 <= ck_s1;
      ck_s3 <= ck_s2;
      rn_s1 <= bus.hyper_reset_ni;
      rn_s2 <= rn_s1;
      dq_d1 <= bus.hyper_dq_i;
      dq_d2 <= dq_d1;
      rw_d1 <= bus.hyper_rwds_i;
      rw_d2 <= rw_d1;
    end
  end

  logic rst;
  logic edge_det;
  logic rise;

  assign rst      = rst_i | ~rn_s2;
  assign edge_det = ck_s2 ^ ck_s3;
  assign rise     = edge_det & ck_s2;

  state_t             state;
  logic [39:0]        ca_sr;
  logic [2:0]         ca_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic               is_rd;
  logic               is_reg;
  logic               is_lin;
  logic               id_sel;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         hi_byte;
  logic               hi_mask;
  logic [15:0]        cr0;
  logic               we;
  logic [1:0]         wmask;
  logic [15:0]        wdata;
  logic [ADDR_W-1:0]  waddr;
  logic [7:0]         dq_out;
  logic               dq_oe;
  logic               rwds_out;
  logic               rwds_oe;

  logic [47:0] ca_full;
  logic [31:0] ca_word;
  logic        unused_ca;

  assign ca_full   = {ca_sr, dq_d2};
  assign ca_word   = {ca_full[44:16], ca_full[2:0]};
  assign unused_ca = ^ca_full[15:3];

  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata;
  logic [15:0] rd_word;

  // Array read runs every cycle on the current address, so the
  // word is always ready long before the next rising CK edge.
  always_ff @(posedge clk_i) begin
    if (we) begin
      if (!wmask[1]) mem[waddr][15:8] <= wdata[15:8];
      if (!wmask[0]) mem[waddr][7:0]  <= wdata[7:0];
    end
    rdata <= mem[addr];
  end

  assign rd_word = is_reg ? (id_sel ? ID0_VALUE : cr0) : rdata;

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic              lin,
    input logic              rg
  );
    if (rg)  return a;
    if (lin) return a + 1'b1;
    return {a[ADDR_W-1:4], a[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state    <= IDLE;
      ca_sr    <= '0;
      ca_cnt   <= '0;
      lat_cnt  <= '0;
      is_rd    <= 1'b0;
      is_reg   <= 1'b0;
      is_lin   <= 1'b0;
      id_sel   <= 1'b0;
      addr     <= '0;
      hi_byte  <= '0;
      hi_mask  <= 1'b0;
      cr0      <= CR0_RESET;
      we       <= 1'b0;
      wmask    <= '0;
      wdata    <= '0;
      waddr    <= '0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= 1'b0;
      rwds_oe  <= 1'b0;
    end else begin
      we <= 1'b0;
      // CS# high wins over any CK edge seen in the same cycle.
      if (cs_s2) begin
        state    <= IDLE;
        dq_out   <= '0;
        dq_oe    <= 1'b0;
        rwds_out <= 1'b0;
        rwds_oe  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state    <= CA;
            ca_cnt   <= '0;
            rwds_oe  <= 1'b1;
            rwds_out <= 1'b1;
          end
          CA: if (edge_det) begin
            ca_sr  <= ca_full[39:0];
            ca_cnt <= ca_cnt + 3'd1;
            if (ca_cnt == 3'd5) begin
              is_rd    <= ca_full[47];
              is_reg   <= ca_full[46];
              is_lin   <= ca_full[45];
              id_sel   <= (ca_word == 32'd0);
              addr     <= ca_word[ADDR_W-1:0];
              lat_cnt  <= '0;
              rwds_oe  <= 1'b0;
              rwds_out <= 1'b0;
              state    <= (!ca_full[47] && ca_full[46]) ? REGWR : LAT;
            end
          end
          LAT: if (edge_det) begin
            if (lat_cnt == LAT_W'(LAT_EDGES - 1)) begin
              lat_cnt <= '0;
              if (is_rd) begin
                state   <= RDATA;
                dq_oe   <= 1'b1;
                rwds_oe <= 1'b1;
              end else begin
                state <= WDATA;
              end
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          WDATA: if (edge_det) begin
            if (rise) begin
              hi_byte <= dq_d2;
              hi_mask <= rw_d2;
            end else begin
              we    <= 1'b1;
              waddr <= addr;
              wdata <= {hi_byte, dq_d2};
              wmask <= {hi_mask, rw_d2};
              addr  <= next_addr(addr, is_lin, is_reg);
            end
          end
          RDATA: if (edge_det) begin
            if (rise) begin
              dq_out   <= rd_word[15:8];
              rwds_out <= 1'b1;
            end else begin
              dq_out   <= rd_word[7:0];
              rwds_out <= 1'b0;
              addr     <= next_addr(addr, is_lin, is_reg);
            end
          end
          REGWR: if (edge_det) begin
            if (rise) begin
              hi_byte <= dq_d2;
            end else begin
              cr0   <= {hi_byte, dq_d2};
              state <= DONE;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.hyper_dq_o      = dq_out;
  assign bus.hyper_dq_oe_o   = dq_oe;
  assign bus.hyper_rwds_o    = rwds_out;
  assign bus.hyper_rwds_oe_o = rwds_oe;

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Directed bench for hyperbus_mem_responder: stimulus pushes expected read
// words into a queue, a monitor pops them as the DUT strobes RWDS.
module tb_hyperbus_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyperbus_mem_responder_if bus();

  hyperbus_mem_responder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [15:0] exp_q[$];
  int          edge_no = 0;
  int          first_edge = 0;
  bit          got_first = 1'b0;
  int          toggles = 0;
  bit          ca_ok = 1'b0;
  logic        prev_oe = 1'b0;
  logic        prev_rw = 1'b0;
  logic [7:0]  hi_seen = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: RWDS rise carries the high byte, fall the low byte.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.hyper_dq_oe_o && prev_oe) begin
        if (bus.hyper_rwds_o != prev_rw) toggles++;
        if (bus.hyper_rwds_o && !prev_rw) begin
          hi_seen = bus.hyper_dq_o;
          if (!got_first) begin
            got_first  = 1'b1;
            first_edge = edge_no;
          end
        end else if (!bus.hyper_rwds_o && prev_rw) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL extra_word: got %h, expected none",
                     {hi_seen, bus.hyper_dq_o});
          end else begin
            chk("rd_word", {16'd0, hi_seen, bus.hyper_dq_o},
                {16'd0, exp_q.pop_front()});
          end
        end
      end
      prev_oe = bus.hyper_dq_oe_o;
      prev_rw = bus.hyper_rwds_o;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ck_edge(input logic [7:0] d, input logic m);
    bus.hyper_dq_i   = d;
    bus.hyper_rwds_i = m;
    tick(2);
    bus.hyper_ck_i = ~bus.hyper_ck_i;
    edge_no++;
    tick(2);
  endtask

  task automatic start(input logic rd, input logic rg, input logic lin,
                       input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
    bus.hyper_cs_ni = 1'b0;
    tick(4);
    ca_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.hyper_dq_i = ca[47-8*i -: 8];
      tick(2);
      ca_ok &= bus.hyper_rwds_oe_o & bus.hyper_rwds_o;
      bus.hyper_ck_i = ~bus.hyper_ck_i;
      tick(2);
    end
    edge_no   = 0;
    got_first = 1'b0;
    toggles   = 0;
  endtask

  task automatic stop();
    tick(2);
    bus.hyper_cs_ni = 1'b1;
    tick(2);
    bus.hyper_ck_i   = 1'b0;
    bus.hyper_dq_i   = '0;
    bus.hyper_rwds_i = 1'b0;
    tick(8);
  endtask

  task automatic lat();
    repeat (24) ck_edge(8'h00, 1'b0);
  endtask

  task automatic wr_word(input logic [15:0] w, input logic [1:0] m);
    ck_edge(w[15:8], m[1]);
    ck_edge(w[7:0], m[0]);
  endtask

  task automatic rd_word(input logic [15:0] w);
    exp_q.push_back(w);
    ck_edge(8'h00, 1'b0);
    ck_edge(8'h00, 1'b0);
  endtask

  task automatic read1(input logic rg, input logic [31:0] a,
                       input logic [15:0] w, input string name);
    start(1'b1, rg, 1'b1, a);
    lat();
    rd_word(w);
    stop();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.hyper_reset_ni = 1'b1;
    bus.hyper_cs_ni    = 1'b1;
    bus.hyper_ck_i     = 1'b0;
    bus.hyper_dq_i     = '0;
    bus.hyper_rwds_i   = 1'b0;
    tick(4);
    chk("reset_out", {20'd0, bus.hyper_dq_o, bus.hyper_dq_oe_o,
        bus.hyper_rwds_o, bus.hyper_rwds_oe_o}, 0);
    rst = 1'b0;
    tick(4);

    start(1'b0, 1'b0, 1'b1, 32'h010);
    lat();
    for (int i = 0; i < 4; i++) wr_word(16'(16'h1111 * (i + 1)), 2'b00);
    stop();

    start(1'b1, 1'b0, 1'b1, 32'h010);
    chk("ca_rwds_high", {31'd0, ca_ok}, 1);
    lat();
    for (int i = 0; i < 4; i++) rd_word(16'(16'h1111 * (i + 1)));
    stop();
    chk("lin_drain", exp_q.size(), 0);
    chk("rwds_toggles", toggles, 8);
    chk("first_data_edge", first_edge, 25);

    start(1'b0, 1'b0, 1'b1, 32'h020);
    lat();
    wr_word(16'h1234, 2'b00);
    stop();
    start(1'b0, 1'b0, 1'b1, 32'h020);
    lat();
    wr_word(16'hABCD, 2'b10);
    stop();
    read1(1'b0, 32'h020, 16'h12CD, "mask_drain");

    start(1'b0, 1'b0, 1'b1, 32'h030);
    lat();
    for (int i = 0; i < 16; i++) wr_word(16'(16'h030 + i), 2'b00);
    stop();
    start(1'b1, 1'b0, 1'b0, 32'h03E);
    lat();
    rd_word(16'h003E);
    rd_word(16'h003F);
    rd_word(16'h0030);
    rd_word(16'h0031);
    stop();
    chk("wrap_drain", exp_q.size(), 0);

    read1(1'b1, 32'h000, 16'h0C81, "id0_drain");
    start(1'b0, 1'b1, 1'b0, 32'h800);
    wr_word(16'h8F17, 2'b00);
    stop();
    read1(1'b1, 32'h800, 16'h8F17, "cr0_drain");

    start(1'b0, 1'b0, 1'b1, 32'h020);
    lat();
    ck_edge(8'hEE, 1'b0);
    stop();
    read1(1'b0, 32'h020, 16'h12CD, "abort_drain");

    start(1'b1, 1'b0, 1'b1, 32'h010);
    lat();
    ck_edge(8'h00, 1'b0);
    chk("pre_rst_oe", {31'd0, bus.hyper_dq_oe_o}, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_out", {20'd0, bus.hyper_dq_o, bus.hyper_dq_oe_o,
        bus.hyper_rwds_o, bus.hyper_rwds_oe_o}, 0);
    bus.hyper_cs_ni = 1'b1;
    bus.hyper_ck_i  = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
    read1(1'b0, 32'h011, 16'h2222, "post_rst_drain");

    bus.hyper_reset_ni = 1'b0;
    tick(6);
    bus.hyper_reset_ni = 1'b1;
    tick(6);
    read1(1'b1, 32'h800, 16'h8F1F, "cr0_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
